// File: rtl/eject_reassembly.sv
// Ejection-port reassembly: collects out-of-order flits into per-packet slots
// and streams each complete packet to the PE in sequence order.
// Optional feature macro: EJECT_STATS_EN (delivered-packet and dropped-flit counters).
module eject_reassembly #(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned ID_W          = 8,
  parameter int unsigned SEQ_W         = 2,
  parameter int unsigned FLITS_PER_PKT = 4,
  parameter int unsigned NUM_SLOT      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_pkt_id,
  input  logic [SEQ_W-1:0]  in_seq,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_pkt_id,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              drop_pulse,
  output logic              dup_pulse,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);

  localparam int unsigned SLOT_W = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
  localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(FLITS_PER_PKT - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [NUM_SLOT-1:0]                                busy_q, busy_d;
  logic [NUM_SLOT-1:0]                                complete_q, complete_d;
  logic [NUM_SLOT-1:0][ID_W-1:0]                      tag_q, tag_d;
  logic [NUM_SLOT-1:0][FLITS_PER_PKT-1:0]             bitmap_q, bitmap_d;
  logic [NUM_SLOT-1:0][FLITS_PER_PKT-1:0][DATA_W-1:0] data_q, data_d;

  logic [0:0]        state_q, state_d;
  logic [SLOT_W-1:0] cur_q, cur_d;
  logic [SEQ_W-1:0]  cnt_q, cnt_d;
  logic [SEQ_W-1:0]  nxt_seq;

  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_pkt_id_q, out_pkt_id_d;
  logic [SEQ_W-1:0]  out_seq_q, out_seq_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              drop_pulse_q, drop_d;
  logic              dup_pulse_q, dup_d;

  logic              match_found, free_found, done_found;
  logic [SLOT_W-1:0] match_idx, free_idx, done_idx;

  // Next state: flit ingest into slots, completion tracking and delivery FSM
  always_comb begin
    busy_d       = busy_q;
    complete_d   = complete_q;
    tag_d        = tag_q;
    bitmap_d     = bitmap_q;
    data_d       = data_q;
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_pkt_id_d = out_pkt_id_q;
    out_seq_d    = out_seq_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    drop_d       = 1'b0;
    dup_d        = 1'b0;
    match_found  = 1'b0;
    match_idx    = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    done_found   = 1'b0;
    done_idx     = '0;
    nxt_seq      = SEQ_W'(cnt_q + SEQ_W'(1));

    // At most one open (busy, not complete) slot can carry a given id
    for (int i = 0; i < NUM_SLOT; i++) begin
      if (busy_q[i] && !complete_q[i] && (tag_q[i] == in_pkt_id)) begin
        match_found = 1'b1;
        match_idx   = SLOT_W'(i);
      end
    end
    // Descending scan leaves the lowest index selected
    for (int i = int'(NUM_SLOT) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
      if (complete_q[i]) begin
        done_found = 1'b1;
        done_idx   = SLOT_W'(i);
      end
    end

    if (in_valid) begin
      if (match_found) begin
        if (bitmap_q[match_idx][in_seq]) begin
          dup_d = 1'b1;
        end else begin
          bitmap_d[match_idx][in_seq] = 1'b1;
          data_d[match_idx][in_seq]   = in_data;
        end
      end else if (free_found) begin
        busy_d[free_idx]           = 1'b1;
        tag_d[free_idx]            = in_pkt_id;
        bitmap_d[free_idx]         = '0;
        bitmap_d[free_idx][in_seq] = 1'b1;
        data_d[free_idx][in_seq]   = in_data;
      end else begin
        drop_d = 1'b1;
      end
    end

    for (int i = 0; i < NUM_SLOT; i++) begin
      if (busy_d[i] && (&bitmap_d[i])) complete_d[i] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (done_found) begin
          state_d      = S_SEND;
          cur_d        = done_idx;
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_pkt_id_d = tag_q[done_idx];
          out_seq_d    = '0;
          out_data_d   = data_q[done_idx][0];
          out_last_d   = (LAST_SEQ == '0);
        end
      end
      default: begin
        if (out_ready) begin
          if (cnt_q == LAST_SEQ) begin
            busy_d[cur_q]     = 1'b0;
            complete_d[cur_q] = 1'b0;
            bitmap_d[cur_q]   = '0;
            state_d           = S_IDLE;
            out_valid_d       = 1'b0;
            out_last_d        = 1'b0;
          end else begin
            cnt_d      = nxt_seq;
            out_seq_d  = nxt_seq;
            out_data_d = data_q[cur_q][nxt_seq];
            out_last_d = (nxt_seq == LAST_SEQ);
          end
        end
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      complete_q   <= '0;
      tag_q        <= '0;
      bitmap_q     <= '0;
      state_q      <= S_IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_pkt_id_q <= '0;
      out_seq_q    <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
      dup_pulse_q  <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      complete_q   <= complete_d;
      tag_q        <= tag_d;
      bitmap_q     <= bitmap_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_pkt_id_q <= out_pkt_id_d;
      out_seq_q    <= out_seq_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      drop_pulse_q <= drop_d;
      dup_pulse_q  <= dup_d;
    end
  end

  // Payload storage; only read once the matching bitmap bit is set
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid  = out_valid_q;
  assign out_pkt_id = out_pkt_id_q;
  assign out_seq    = out_seq_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign drop_pulse = drop_pulse_q;
  assign dup_pulse  = dup_pulse_q;

`ifdef EJECT_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        last_beat_c;

  assign last_beat_c = (state_q == S_SEND) && out_ready && (cnt_q == LAST_SEQ);

  // Saturating statistics counters
  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (last_beat_c && (pkt_count_q != 16'hFFFF)) pkt_count_d = pkt_count_q + 16'd1;
    if (drop_d && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_eject_reassembly.sv
// Bench for eject_reassembly: table-driven in-order packet, directed corner
// sequences and random traffic, all cross-checked against a slot-level model.
module tb_eject_reassembly;

`ifdef EJECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_pkt_id;
  logic [1:0]  in_seq;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pkt_id;
  logic [1:0]  out_seq;
  logic [63:0] out_data;
  logic        out_last;
  logic        drop_pulse;
  logic        dup_pulse;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  eject_reassembly dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pkt_id  (in_pkt_id),
    .in_seq     (in_seq),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pkt_id (out_pkt_id),
    .out_seq    (out_seq),
    .out_data   (out_data),
    .out_last   (out_last),
    .drop_pulse (drop_pulse),
    .dup_pulse  (dup_pulse),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  // ---------------- reference model: slots as plain arrays ----------------
  bit          m_busy [4];
  bit          m_done [4];
  bit          m_have [4][4];
  logic [7:0]  m_tag  [4];
  logic [63:0] m_data [4][4];
  int          m_send;   // slot being delivered, -1 when none
  int          m_beat;
  bit          m_drop, m_dup;
  int          m_pkts, m_drops;

  task automatic model_advance(input bit rst, input bit v, input logic [7:0] id,
                               input logic [1:0] sq, input logic [63:0] d, input bit rdy);
    int pick, fin, hit, fr, got;
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        m_busy[s] = 0; m_done[s] = 0;
        for (int k = 0; k < 4; k++) m_have[s][k] = 0;
      end
      m_send = -1; m_beat = 0; m_drop = 0; m_dup = 0; m_pkts = 0; m_drops = 0;
      return;
    end
    pick = -1; fin = -1;
    if (m_send < 0) begin
      for (int s = 3; s >= 0; s--) if (m_done[s]) pick = s;
    end else if (rdy) begin
      if (m_beat == 3) begin
        fin = m_send;
        if (m_pkts < 65535) m_pkts++;
      end else m_beat++;
    end
    m_drop = 0; m_dup = 0;
    if (v) begin
      hit = -1; fr = -1;
      for (int s = 0; s < 4; s++) if (m_busy[s] && !m_done[s] && m_tag[s] == id) hit = s;
      for (int s = 3; s >= 0; s--) if (!m_busy[s]) fr = s;
      if (hit >= 0) begin
        if (m_have[hit][sq]) m_dup = 1;
        else begin m_have[hit][sq] = 1; m_data[hit][sq] = d; end
      end else if (fr >= 0) begin
        m_busy[fr] = 1; m_tag[fr] = id;
        for (int k = 0; k < 4; k++) m_have[fr][k] = 0;
        m_have[fr][sq] = 1; m_data[fr][sq] = d;
      end else begin
        m_drop = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    for (int s = 0; s < 4; s++) begin
      got = 0;
      for (int k = 0; k < 4; k++) got += int'(m_have[s][k]);
      if (m_busy[s] && got == 4) m_done[s] = 1;
    end
    if (fin >= 0) begin m_busy[fin] = 0; m_done[fin] = 0; m_send = -1; end
    if (pick >= 0) begin m_send = pick; m_beat = 0; end
  endtask

  function automatic logic [127:0] pack_obs(input logic v, input logic [7:0] id,
      input logic [1:0] sq, input logic [63:0] d, input logic l, input logic dp,
      input logic du, input logic [15:0] pc, input logic [15:0] dc);
    return {18'h0, v, (v ? {id, sq, d, l} : 75'h0), dp, du, pc, dc};
  endfunction

  function automatic logic [127:0] obs_dut();
    return pack_obs(out_valid, out_pkt_id, out_seq, out_data, out_last,
                    drop_pulse, dup_pulse, pkt_count, drop_count);
  endfunction

  function automatic logic [127:0] obs_model();
    int s;
    s = (m_send < 0) ? 0 : m_send;
    return pack_obs(m_send >= 0, m_tag[s], 2'(m_beat), m_data[s][m_beat], m_beat == 3,
                    m_drop, m_dup, STATS ? 16'(m_pkts) : 16'h0, STATS ? 16'(m_drops) : 16'h0);
  endfunction

  function automatic logic [63:0] dfun(input logic [7:0] id, input logic [1:0] s);
    return {32'hC0DE0000, 16'h0, id, 6'h0, s};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check current outputs against the model, drive, advance
  task automatic cycle(input bit rst, input bit v, input logic [7:0] id,
                       input logic [1:0] sq, input logic [63:0] d, input bit rdy);
    if (model_on) chk("model", obs_dut(), obs_model());
    reset = rst; in_valid = v; in_pkt_id = id; in_seq = sq; in_data = d; out_ready = rdy;
    model_advance(rst, v, id, sq, d, rdy);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 8'h0, 2'h0, 64'h0, rdy);
  endtask

  task automatic flit(input logic [7:0] id, input logic [1:0] sq);
    cycle(1'b0, 1'b1, id, sq, dfun(id, sq), 1'b0);
  endtask

  // Wait (bounded) for a packet and drain its four beats with out_ready=1
  task automatic expect_pkt(input logic [7:0] id);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin idle(1'b0); n++; end
    chk("pkt_wait", 128'(out_valid), 128'(1'b1));
    for (int b = 0; b < 4; b++) begin
      chk("pkt_beat", {out_pkt_id, out_seq, out_data, out_last},
          {id, 2'(b), dfun(id, 2'(b)), b == 3});
      idle(1'b1);
    end
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  id;
    logic [1:0]  sq;
    logic [63:0] d;
    logic        rdy;
    logic        ev;
    logic [7:0]  eid;
    logic [1:0]  esq;
    logic [63:0] ed;
    logic        el;
    logic [15:0] epc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // In-order packet 8'h11: flits on cycles 1-4, delivery on cycles 6-9
    for (int c = 0; c < 11; c++) begin
      tbl[c] = '{v: 1'b0, id: 8'h0, sq: 2'h0, d: 64'h0, rdy: 1'b1,
                 ev: 1'b0, eid: 8'h0, esq: 2'h0, ed: 64'h0, el: 1'b0, epc: 16'h0};
      if (c >= 1 && c <= 4) begin
        tbl[c].v = 1'b1; tbl[c].id = 8'h11; tbl[c].sq = 2'(c - 1); tbl[c].d = 64'hA0 + 64'(c - 1);
      end
      if (c >= 6 && c <= 9) begin
        tbl[c].ev = 1'b1; tbl[c].eid = 8'h11; tbl[c].esq = 2'(c - 6);
        tbl[c].ed = 64'hA0 + 64'(c - 6); tbl[c].el = (c == 9);
      end
      if (c == 10) tbl[c].epc = STATS ? 16'd1 : 16'd0;
    end

    reset = 1'b1; in_valid = 0; in_pkt_id = 0; in_seq = 0; in_data = 0; out_ready = 0;
    model_advance(1'b1, 1'b0, 8'h0, 2'h0, 64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs_dut(), 128'h0);
    model_on = 1'b1;

    for (int c = 0; c < 11; c++) begin
      chk("table", obs_dut(), pack_obs(tbl[c].ev, tbl[c].eid, tbl[c].esq, tbl[c].ed,
                                       tbl[c].el, 1'b0, 1'b0, tbl[c].epc, 16'h0));
      cycle(1'b0, tbl[c].v, tbl[c].id, tbl[c].sq, tbl[c].d, tbl[c].rdy);
    end

    // Out-of-order arrival is delivered in sequence order
    flit(8'h22, 2'd3); flit(8'h22, 2'd1); flit(8'h22, 2'd0); flit(8'h22, 2'd2);
    expect_pkt(8'h22);

    // Interleaved packets: 8'h44 (slot 1) completes first and goes first
    flit(8'h33, 2'd0); flit(8'h44, 2'd0); flit(8'h44, 2'd1); flit(8'h33, 2'd1);
    flit(8'h44, 2'd2); flit(8'h44, 2'd3); flit(8'h33, 2'd2); flit(8'h33, 2'd3);
    expect_pkt(8'h44);
    expect_pkt(8'h33);
    idle(1'b0);

    // Five ids, four slots: fifth flit is dropped, the rest unaffected
    for (int i = 0; i < 5; i++) flit(8'h60 + 8'(i), 2'd0);
    chk("drop_pulse", {drop_pulse, drop_count}, {1'b1, STATS ? 16'd1 : 16'd0});
    for (int s = 1; s < 4; s++)
      for (int i = 0; i < 4; i++) flit(8'h60 + 8'(i), 2'(s));
    for (int i = 0; i < 4; i++) expect_pkt(8'h60 + 8'(i));
    idle(1'b0);

    // Duplicate seq 1 with different data is ignored
    flit(8'h55, 2'd0); flit(8'h55, 2'd1);
    cycle(1'b0, 1'b1, 8'h55, 2'd1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    chk("dup_pulse", 128'(dup_pulse), 128'(1'b1));
    flit(8'h55, 2'd2); flit(8'h55, 2'd3);
    expect_pkt(8'h55);
    idle(1'b0);

    // Backpressure mid-packet, then reset during SEND
    for (int s = 0; s < 4; s++) flit(8'h66, 2'(s));
    for (int n = 0; n < 20 && !out_valid; n++) idle(1'b0);
    idle(1'b1); idle(1'b1);
    for (int n = 0; n < 3; n++) begin
      chk("stall_hold", {out_valid, out_pkt_id, out_seq, out_data, out_last},
          {1'b1, 8'h66, 2'd2, dfun(8'h66, 2'd2), 1'b0});
      idle(1'b0);
    end
    idle(1'b1);
    chk("beat3", {out_valid, out_seq, out_last}, {1'b1, 2'd3, 1'b1});
    cycle(1'b1, 1'b0, 8'h0, 2'h0, 64'h0, 1'b0);
    chk("reset_send", obs_dut(), 128'h0);
    for (int i = 0; i < 4; i++) flit(8'h70 + 8'(i), 2'd0);
    chk("slots_free", 128'(drop_pulse), 128'(1'b0));
    cycle(1'b1, 1'b0, 8'h0, 2'h0, 64'h0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
            8'h80 + 8'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    chk("model_final", obs_dut(), obs_model());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
